shift_register_256: RTL and testbench

- Serial-in/serial-out bidirectional shift register, 256 bits deep by default.
- Delays a 1-bit stream by DEPTH enabled clock cycles.
- Supports either shift direction.
- Used as a long serial delay line / bit-stream buffer; no parallel load or readout.

---
 rtl/shift_register_256_pkg.sv | 10 +
 rtl/shift_register_256.sv | 36 +++
 tb/tb_shift_register_256.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_256_pkg.sv
// Shared constants for the 256-bit serial delay line: default depth and
// the shift-direction encodings used on the shift_dir port.
package shift_register_256_pkg;

  localparam int DEPTH_DEFAULT = 256;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_register_256_pkg

// File: rtl/shift_register_256.sv
// Bidirectional serial-in/serial-out shift register: delays a 1-bit stream
// by DEPTH enabled clock cycles, shifting toward the MSB or the LSB.
module shift_register_256
  import shift_register_256_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic shift_dir,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      if (shift_dir == DIR_LEFT) begin
        sr <= {sr[DEPTH-2:0], din};
      end else begin
        sr <= {din, sr[DEPTH-1:1]};
      end
    end
  end

  // Output end follows the live direction, so flipping shift_dir re-selects
  // the opposite end immediately; din never reaches dout combinationally.
  assign dout = (shift_dir == DIR_LEFT) ? sr[DEPTH-1] : sr[0];

endmodule : shift_register_256

// File: tb/tb_shift_register_256.sv
// Self-checking bench for shift_register_256: per-edge expected dout values
// flow through a scoreboard queue and are compared as the DUT produces them.
module tb_shift_register_256;

  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;
  logic en;
  logic din;
  logic shift_dir;
  logic dout;

  int   total;
  int   bad;
  logic exp_q[$];
  logic exp_bit;

  shift_register_256 #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .shift_dir(shift_dir),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [DEPTH-1:0] zero_vec;
    zero_vec  = '0;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial dout=%b exp=0", dout);
    end
    // Fill with ones so reset has something visible to clear.
    shift_dir = 1'b0;
    en        = 1'b1;
    din       = 1'b1;
    for (int e = 0; e < DEPTH + 4; e++) step();
    total++;
    if (dout !== 1'b1) begin
      bad++;
      $display("FAIL reset_prefill dout=%b exp=1", dout);
    end
    // Assert reset mid-cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_left dout=%b exp=0", dout);
    end
    shift_dir = 1'b1;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_right dout=%b exp=0", dout);
    end
    // Enabled edges while reset is held must not shift anything in.
    for (int e = 0; e < 3; e++) step();
    rst_n = 1'b1;
    en    = 1'b0;
    step();
    total++;
    if (dut.sr !== zero_vec) begin
      bad++;
      $display("FAIL reset_release sr=%h exp=0", dut.sr);
    end
    shift_dir = 1'b0;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_dout dout=%b exp=0", dout);
    end
  endtask

  task automatic test_left_latency();
    do_reset();
    shift_dir = 1'b0;
    en        = 1'b1;
    for (int e = 1; e <= DEPTH + 1; e++) begin
      din = (e == 1);
      exp_q.push_back(e == DEPTH);
      step();
      exp_bit = exp_q.pop_front();
      total++;
      if (dout !== exp_bit) begin
        bad++;
        $display("FAIL left_latency edge=%0d dout=%b exp=%b", e, dout, exp_bit);
      end
    end
  endtask

  task automatic test_left_pattern();
    logic [3:0] pat;
    pat = 4'b0101;  // sequence 1,0,1,0 from bit 0 upward
    do_reset();
    shift_dir = 1'b0;
    en        = 1'b1;
    for (int e = 1; e <= DEPTH + 5; e++) begin
      din = (e <= 4) ? pat[e-1] : 1'b0;
      if (e >= DEPTH && e <= DEPTH + 3) exp_q.push_back(pat[e-DEPTH]);
      else                              exp_q.push_back(1'b0);
      step();
      exp_bit = exp_q.pop_front();
      total++;
      if (dout !== exp_bit) begin
        bad++;
        $display("FAIL left_pattern edge=%0d dout=%b exp=%b", e, dout, exp_bit);
      end
    end
  endtask

  task automatic test_hold();
    logic [DEPTH-1:0] exp_vec;
    exp_vec     = '0;
    exp_vec[99] = 1'b1;
    do_reset();
    shift_dir = 1'b0;
    en        = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      din = (e == 1);
      step();
    end
    en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      din = c[0];
      step();
      total++;
      if (dout !== 1'b0) begin
        bad++;
        $display("FAIL hold_dout cycle=%0d dout=%b exp=0", c, dout);
      end
    end
    total++;
    if (dut.sr !== exp_vec) begin
      bad++;
      $display("FAIL hold_state sr=%h exp=%h", dut.sr, exp_vec);
    end
    en  = 1'b1;
    din = 1'b0;
    for (int e = 1; e <= 157; e++) begin
      exp_q.push_back(e == 156);
      step();
      exp_bit = exp_q.pop_front();
      total++;
      if (dout !== exp_bit) begin
        bad++;
        $display("FAIL hold_resume edge=%0d dout=%b exp=%b", e, dout, exp_bit);
      end
    end
  endtask

  task automatic test_right();
    do_reset();
    shift_dir = 1'b1;
    en        = 1'b1;
    for (int e = 1; e <= DEPTH + 1; e++) begin
      din = (e == 1);
      exp_q.push_back(e == DEPTH);
      step();
      if (e == 1) begin
        total++;
        if (dut.sr[DEPTH-1] !== 1'b1) begin
          bad++;
          $display("FAIL right_entry sr_msb=%b exp=1", dut.sr[DEPTH-1]);
        end
      end
      exp_bit = exp_q.pop_front();
      total++;
      if (dout !== exp_bit) begin
        bad++;
        $display("FAIL right_latency edge=%0d dout=%b exp=%b", e, dout, exp_bit);
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    shift_dir = 1'b0;
    en        = 1'b1;
    din       = 1'b1;
    step();
    // The single 1 now sits at bit 0: flipping direction exposes it at once.
    shift_dir = 1'b1;
    #1;
    total++;
    if (dout !== 1'b1) begin
      bad++;
      $display("FAIL dir_mux_right dout=%b exp=1", dout);
    end
    shift_dir = 1'b0;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL dir_mux_left dout=%b exp=0", dout);
    end
    din = 1'b0;
    for (int e = 2; e <= 10; e++) step();
    shift_dir = 1'b1;
    #1;
    total++;
    if (dout !== 1'b0) begin
      bad++;
      $display("FAIL reversal_switch dout=%b exp=0", dout);
    end
    for (int e = 1; e <= 10; e++) begin
      exp_q.push_back(e == 9);
      step();
      exp_bit = exp_q.pop_front();
      total++;
      if (dout !== exp_bit) begin
        bad++;
        $display("FAIL reversal edge=%0d dout=%b exp=%b", e, dout, exp_bit);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    din       = 1'b0;
    shift_dir = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    test_reset();
    test_left_latency();
    test_left_pattern();
    test_hold();
    test_right();
    test_reversal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_register_256
